// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter: shares the single sync_fifo write port among NREQ producers,
// granting one owner at a time for bursts of up to BURST_MAX words, throttled by fifo_full.
module sync_fifo_wr_arb #(
   parameter int NREQ      = 4,
   parameter int IDW       = 2,
   parameter int DW        = 8,
   parameter int BURST_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*DW-1:0]  din,
   input  logic                fifo_full,
   output logic [NREQ-1:0]     gnt,
   output logic                fifo_wr,
   output logic [DW-1:0]       fifo_din,
   output logic                busy,
   output logic [IDW-1:0]      owner
);

   localparam int CW = $clog2(BURST_MAX + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic             found;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   cand;
   logic             wr;

   // Search last+1, last+2, ... so the previous owner is considered last.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_q) + k) % NREQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign wr    = (state_q == BURST) & req[owner_q] & ~fifo_full & ~rst;
   assign busy  = (state_q == BURST);
   assign owner = owner_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      owner_d  = owner_q;
      gnt      = '0;
      fifo_wr  = wr;
      fifo_din = '0;
      if (state_q == BURST)
         fifo_din = din[owner_q*DW +: DW];
      if (wr)
         gnt[owner_q] = 1'b1;

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BURST;
               owner_d = winner;
               cnt_d   = '0;
            end
         end
         BURST: begin
            if (wr) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(BURST_MAX - 1)) begin
                  state_d = IDLE;
                  last_d  = owner_q;
                  cnt_d   = '0;
               end
            end else if (!req[owner_q]) begin
               // Producer withdrew; a full-stall with req held stays put.
               state_d = IDLE;
               last_d  = owner_q;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= IDW'(NREQ - 1);
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: producer models feed words, a scoreboard holds the expected
// (owner, data, cycle) of every write and a monitor checks each fifo_wr against it.
module tb_sync_fifo_wr_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] din = '0;
   logic        fifo_full = 1'b0;
   logic [3:0]  gnt;
   logic        fifo_wr;
   logic [7:0]  fifo_din;
   logic        busy;
   logic [1:0]  owner;

   sync_fifo_wr_arb #(.NREQ(4), .IDW(2), .DW(8), .BURST_MAX(4)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .fifo_full(fifo_full),
      .gnt(gnt), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         own;
      logic [7:0] data;
      int         rel;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         t0 = 0;
   logic [7:0] pmem [4][16];
   int         phead [4];
   int         ptail [4];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req[i]       = (phead[i] != ptail[i]);
         din[i*8 +: 8] = pmem[i][phead[i] % 16];
      end
   endtask

   task automatic put(input int p, input logic [7:0] w);
      pmem[p][ptail[p]] = w;
      ptail[p]++;
   endtask

   task automatic expect_wr(input int o, input logic [7:0] d, input int r);
      exp_t e;
      e.own = o; e.data = d; e.rel = r;
      sb.push_back(e);
   endtask

   task automatic clear_prod();
      for (int i = 0; i < 4; i++) begin
         phead[i] = 0;
         ptail[i] = 0;
      end
      drive();
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #2;
   endtask

   // Producer models: pop the presented word after each granted edge.
   initial begin
      logic [3:0] g;
      forever begin
         @(negedge clk);
         g = gnt;
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++)
            if (g[i] === 1'b1 && phead[i] != ptail[i]) phead[i]++;
         drive();
      end
   end

   // Monitor: invariants every cycle, scoreboard pop on each write.
   initial forever begin
      exp_t e;
      int   rel;
      @(negedge clk);
      rel = cyc - t0;
      if (rst === 1'b1) begin
         checks++;
         if (fifo_wr !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL rst_force: fifo_wr=%b gnt=%b, required 0/0000", fifo_wr, gnt);
         end
      end
      if (fifo_full === 1'b1) begin
         checks++;
         if (fifo_wr !== 1'b0) begin
            errors++;
            $display("FAIL full_guard: fifo_wr=%b while fifo_full=1, required 0", fifo_wr);
         end
      end
      checks++;
      if ($countones(gnt) > 1 || fifo_wr !== (gnt != 4'b0)) begin
         errors++;
         $display("FAIL gnt_onehot: gnt=%b fifo_wr=%b, required one-hot matching fifo_wr", gnt, fifo_wr);
      end
      if (fifo_wr === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_wr: rel=%0d gnt=%b din=%0d, required no write", rel, gnt, fifo_din);
         end else begin
            e = sb.pop_front();
            if (gnt !== (4'b1 << e.own) || fifo_din !== e.data || owner !== 2'(e.own) ||
                busy !== 1'b1 || rel != e.rel) begin
               errors++;
               $display("FAIL write: got owner=%0d gnt=%b din=%0d busy=%b rel=%0d, required owner=%0d din=%0d rel=%0d",
                        owner, gnt, fifo_din, busy, rel, e.own, e.data, e.rel);
            end
         end
      end
   end

   task automatic apply_reset();
      next_cyc();
      rst = 1'b1;
      fifo_full = 1'b0;
      clear_prod();
      next_cyc();
      rst = 1'b0;
   endtask

   task automatic finish_test(input string name);
      for (int i = 0; i < 60 && sb.size() != 0; i++) next_cyc();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d writes outstanding, required 0", name, sb.size());
         sb.delete();
      end
      repeat (3) next_cyc();
      checks++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b fifo_wr=%b, required 0/0", name, busy, fifo_wr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Test 1: reset held 2 cycles with all producers requesting.
      clear_prod();
      for (int i = 0; i < 4; i++) put(i, 8'(8'h10 * (i + 1)));
      drive();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (gnt !== 4'b0 || fifo_wr !== 1'b0 || busy !== 1'b0 || fifo_din !== 8'h00 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b wr=%b busy=%b din=%0d owner=%0d, required 0",
                     gnt, fifo_wr, busy, fifo_din, owner);
         end
      end
      next_cyc();
      clear_prod();
      next_cyc();
      rst = 1'b0;
      finish_test("reset");

      // Test 2: single producer, 6 words split 4 + 2 with one arbitration gap.
      apply_reset();
      begin
         logic [7:0] w [6];
         w = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
         for (int j = 0; j < 6; j++) put(0, w[j]);
         for (int j = 0; j < 4; j++) expect_wr(0, w[j], 1 + j);
         expect_wr(0, w[4], 6);
         expect_wr(0, w[5], 7);
      end
      t0 = cyc;
      drive();
      finish_test("single");

      // Test 3: all request; owners rotate 0,1,2,3,0.
      apply_reset();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < ((i == 0) ? 8 : 4); j++) put(i, 8'(8'h10 * (i + 1) + j));
      for (int b = 0; b < 5; b++)
         for (int j = 0; j < 4; j++)
            expect_wr(b % 4, 8'(8'h10 * ((b % 4) + 1) + ((b == 4) ? 4 + j : j)), 1 + 5 * b + j);
      t0 = cyc;
      drive();
      finish_test("rrobin");

      // Test 4: fifo_full stall for 3 cycles after the 2nd write of owner 2.
      apply_reset();
      for (int j = 0; j < 4; j++) put(2, 8'(8'hA0 + j));
      expect_wr(2, 8'hA0, 1);
      expect_wr(2, 8'hA1, 2);
      expect_wr(2, 8'hA2, 6);
      expect_wr(2, 8'hA3, 7);
      t0 = cyc;
      drive();
      repeat (3) next_cyc();
      fifo_full = 1'b1;
      repeat (3) next_cyc();
      fifo_full = 1'b0;
      finish_test("stall");

      // Test 5: reset during the 3rd write cycle of owner 1; req[0] then wins.
      apply_reset();
      for (int j = 0; j < 4; j++) put(1, 8'(8'hB0 + j));
      expect_wr(1, 8'hB0, 1);
      expect_wr(1, 8'hB1, 2);
      expect_wr(0, 8'hC0, 5);
      expect_wr(0, 8'hC1, 6);
      expect_wr(1, 8'hB2, 9);
      expect_wr(1, 8'hB3, 10);
      t0 = cyc;
      drive();
      repeat (3) next_cyc();
      rst = 1'b1;
      put(0, 8'hC0);
      put(0, 8'hC1);
      drive();
      next_cyc();
      rst = 1'b0;
      finish_test("midrst");

      // Test 6: last=1 with req=1010 -> owner 3 then owner 1.
      apply_reset();
      put(1, 8'hD0);
      expect_wr(1, 8'hD0, 1);
      expect_wr(3, 8'hE0, 4);
      expect_wr(3, 8'hE1, 5);
      expect_wr(1, 8'hD1, 8);
      expect_wr(1, 8'hD2, 9);
      t0 = cyc;
      drive();
      repeat (3) next_cyc();
      put(3, 8'hE0);
      put(3, 8'hE1);
      put(1, 8'hD1);
      put(1, 8'hD2);
      drive();
      finish_test("wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
